dmem_responder: RTL and testbench
=================================

# dmem_responder

Data-memory responder for the processor's data bus: the memory-side counterpart of the MEM stage. It accepts one `BUS_LOAD`/`BUS_STORE`/`BUS_NONE` command per cycle on the `proc2Dmem_*` signals. It performs word writes into an internal array and returns load data on `Dmem2proc_data` after a fixed, parameterised latency through a response pipeline. It also flags misaligned and out-of-range accesses and keeps access counters for debug and performance monitoring.

## Interface
- `DEPTH`, 1024: number of 32-bit words in the array. Power of two, 16..65536.
- `LATENCY`, 1: load response latency in cycles, legal range 0..4. 0 gives a combinational read.
- `clk`  in  1  system clock; all state updates on its rising edge.
- `rst`  in  1  reset; asynchronous, active-low.
- `proc2Dmem_command`  in  2  `BUS_NONE` / `BUS_LOAD` / `BUS_STORE` (sys_defs encodings); any other code is treated as `BUS_NONE`.
- `proc2Dmem_addr`  in  32  byte address.
- `proc2Dmem_data`  in  32  store data.
- `Dmem2proc_data`  out  32  load response data.
- `Dmem2proc_valid`  out  1  load response present this cycle.
- `Dmem2proc_err`  out  1  errored command completes this cycle; applies to loads and stores.
- `err_sticky`  out  1  set by any error; cleared only by reset.
- `ld_count`  out  16  accepted loads, including errored ones; saturates at 16'hFFFF.
- `st_count`  out  16  accepted stores, including errored ones; saturates at 16'hFFFF.

## Operation
- Word index is `addr[31:2]`.
  - Misaligned: `addr[1:0] != 0`.
  - Out of range: index >= `DEPTH`.
  - Either condition makes the command an error.
- Store, no error: `mem[idx] <= proc2Dmem_data` at the end of the issue cycle.
- Store, error: array unchanged.
- Load data is sampled from the array at issue, combinationally from the current array contents. Errored loads return 32'h0.
- Response pipeline (`LATENCY` >= 1): `LATENCY` register stages, each holding `{valid, err, data}`.
  - Each stage is loaded every cycle; there are no bubbles and no stall.
  - Stores enter the pipeline with valid=0 and carry only err.
- `LATENCY` == 0: all three outputs are driven combinationally from the issue-cycle command.
- `Dmem2proc_data` is 32'h0 whenever `Dmem2proc_valid` is 0.
- Counters increment by 1 at the end of the issue cycle and hold at 16'hFFFF once reached.
- `err_sticky` sets at the issue cycle of an errant command. It therefore rises before the response-aligned `Dmem2proc_err` pulse.
- Array contents are not cleared by reset. Reads before any write return undefined data; the bench must write first.

## Timing
- Load issued in cycle N: `Dmem2proc_valid`/`Dmem2proc_data` appear in cycle N+`LATENCY` for exactly one cycle.
- Back-to-back loads: one response per cycle, in issue order.
- Store at N, load to the same address at N+1: the load returns the new data.
- Load at N, store to the same address at N+1, with `LATENCY` >= 2: the load returns the old data, because data is captured at issue.
- Errored command at N: `Dmem2proc_err`=1 in cycle N+`LATENCY`. For an errored load, valid=1 and data=0 in that cycle.
- Reset asserted: asynchronously clears all pipeline stages, outputs, counters and `err_sticky` to 0.
  - In-flight responses are discarded.
  - No response is emitted after reset release for commands issued before reset.
- First command is accepted on the first rising edge after `rst` deasserts.

## Test plan
- `LATENCY`=1: STORE addr 32'h10 data 32'hDEADBEEF at N, LOAD 32'h10 at N+1.
  - Required: valid=1 and data=32'hDEADBEEF at N+2.
  - Required: `st_count`=1 and `ld_count`=1.
- `LATENCY`=3: 4 back-to-back LOADs of preloaded words 0..3 holding 32'h1..32'h4.
  - Required: valid high in cycles N+3..N+6 with data 1,2,3,4 in that order.
  - Required: data is 0 in all other cycles.
- Misaligned STORE to 32'h13 with data 32'hFFFF_FFFF, then LOAD 32'h10 (prewritten 32'h5A5A5A5A).
  - Required: `Dmem2proc_err` pulses on the store's completion slot, `err_sticky`=1.
  - Required: the load returns 32'h5A5A5A5A, showing the array is unchanged.
- Out-of-range LOAD with `DEPTH`=1024 to addr 32'h1000.
  - Required: valid=1, err=1, data=32'h0 at N+`LATENCY`.
  - Required: `ld_count` increments.
- `LATENCY`=2: LOAD 32'h20 (old value 32'h1) at N, STORE 32'h20 with 32'h2 at N+1.
  - Required: response at N+2 is 32'h1.
  - Required: a LOAD at N+2 returns 32'h2 at N+4.
- Reset with 2 loads in flight (`LATENCY`=3): assert `rst` low mid-cycle.
  - Required: outputs go to 0 immediately and counters read 0.
  - Required: no valid pulses after release until a new LOAD is issued.
  - Separately: drive 65536+2 stores and check `st_count` holds at 16'hFFFF.

Source files
------------

// File: rtl/dmem_responder.sv
// Data-memory responder: word store/load array with a fixed-latency response
// pipeline, misalignment/range error flagging and saturating access counters.
module dmem_responder #(
  parameter int unsigned DEPTH   = 1024,
  parameter int unsigned LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  proc2Dmem_command,
  input  logic [31:0] proc2Dmem_addr,
  input  logic [31:0] proc2Dmem_data,
  output logic [31:0] Dmem2proc_data,
  output logic        Dmem2proc_valid,
  output logic        Dmem2proc_err,
  output logic        err_sticky,
  output logic [15:0] ld_count,
  output logic [15:0] st_count
);

  localparam int unsigned IDX_W  = $clog2(DEPTH);
  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 16;
  localparam logic [1:0]  BUS_LOAD  = 2'h1;
  localparam logic [1:0]  BUS_STORE = 2'h2;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef struct packed {
    logic              valid;
    logic              err;
    logic [DATA_W-1:0] data;
  } rsp_t;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [29:0]      word_idx;
  logic [IDX_W-1:0] mem_idx;
  logic             is_load;
  logic             is_store;
  logic             cmd_err;
  rsp_t             issue_rsp;
  rsp_t             out_rsp;

  // Decode the issue-cycle command; unknown codes fall through as no-ops.
  always_comb begin
    word_idx = proc2Dmem_addr[31:2];
    mem_idx  = proc2Dmem_addr[IDX_W+1:2];
    is_load  = (proc2Dmem_command == BUS_LOAD);
    is_store = (proc2Dmem_command == BUS_STORE);
    cmd_err  = (is_load || is_store) &&
               ((proc2Dmem_addr[1:0] != 2'b00) || (word_idx >= 30'(DEPTH)));
  end

  // Load data is captured at issue so a later store cannot disturb it.
  always_comb begin
    issue_rsp       = '0;
    issue_rsp.valid = is_load;
    issue_rsp.err   = cmd_err;
    if (is_load && !cmd_err) begin
      issue_rsp.data = mem[mem_idx];
    end
  end

  // Array is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (is_store && !cmd_err) begin
      mem[mem_idx] <= proc2Dmem_data;
    end
  end

  generate
    if (LATENCY == 0) begin : g_comb
      assign out_rsp = issue_rsp;
    end else begin : g_pipe
      rsp_t [LATENCY-1:0] stage;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          stage <= '0;
        end else begin
          stage[0] <= issue_rsp;
          for (int unsigned i = 1; i < LATENCY; i++) begin
            stage[i] <= stage[i-1];
          end
        end
      end

      assign out_rsp = stage[LATENCY-1];
    end
  endgenerate

  assign Dmem2proc_valid = out_rsp.valid;
  assign Dmem2proc_err   = out_rsp.err;
  assign Dmem2proc_data  = out_rsp.data;

  // Issue-aligned debug state: saturating counters and sticky error.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ld_count   <= '0;
      st_count   <= '0;
      err_sticky <= 1'b0;
    end else begin
      if (is_load && (ld_count != CNT_MAX)) begin
        ld_count <= ld_count + CNT_W'(1);
      end
      if (is_store && (st_count != CNT_MAX)) begin
        st_count <= st_count + CNT_W'(1);
      end
      if (cmd_err) begin
        err_sticky <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench: one stimulus stream drives LATENCY 0..3 instances; each
// instance has its own expected-response queue drained by a monitor.
module tb_dmem_responder;

  localparam int unsigned NINST = 4;

  typedef struct packed {
    logic        v;
    logic        e;
    logic [31:0] d;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [1:0]  cmd;
  logic [31:0] addr;
  logic [31:0] wdata;

  logic [31:0] rd [NINST];
  logic        rv [NINST];
  logic        re [NINST];
  logic        es [NINST];
  logic [15:0] lc [NINST];
  logic [15:0] sc [NINST];

  exp_t q [NINST][$];
  exp_t mon_e;
  int   checks;
  int   fails;

  genvar g;
  generate
    for (g = 0; g < NINST; g++) begin : g_dut
      dmem_responder #(.DEPTH(1024), .LATENCY(g)) u_dut (
        .clk               (clk),
        .rst               (rst),
        .proc2Dmem_command (cmd),
        .proc2Dmem_addr    (addr),
        .proc2Dmem_data    (wdata),
        .Dmem2proc_data    (rd[g]),
        .Dmem2proc_valid   (rv[g]),
        .Dmem2proc_err     (re[g]),
        .err_sticky        (es[g]),
        .ld_count          (lc[g]),
        .st_count          (sc[g])
      );
    end
  endgenerate

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Monitor: instance L shows the command issued L cycles earlier.
  always @(negedge clk) begin
    if (rst) begin
      for (int l = 0; l < NINST; l++) begin
        if (q[l].size() > l) begin
          mon_e = q[l].pop_front();
          checks++;
          if ({rv[l], re[l], rd[l]} !== mon_e) begin
            fails++;
            $display("FAIL rsp_L%0d t=%0t: got v=%0b e=%0b d=%h, want v=%0b e=%0b d=%h",
                     l, $time, rv[l], re[l], rd[l], mon_e.v, mon_e.e, mon_e.d);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h, want %h", name, got, want);
    end
  endtask

  task automatic chk_all(input logic [15:0] want_ld, input logic [15:0] want_st,
                         input logic want_sticky);
    for (int l = 0; l < NINST; l++) begin
      chk($sformatf("ld_count_L%0d", l), 32'(lc[l]), 32'(want_ld));
      chk($sformatf("st_count_L%0d", l), 32'(sc[l]), 32'(want_st));
      chk($sformatf("err_sticky_L%0d", l), 32'(es[l]), 32'(want_sticky));
    end
  endtask

  task automatic chk_outputs_zero(input string tag);
    for (int l = 0; l < NINST; l++) begin
      chk($sformatf("%s_valid_L%0d", tag, l), 32'(rv[l]), 32'h0);
      chk($sformatf("%s_err_L%0d", tag, l), 32'(re[l]), 32'h0);
      chk($sformatf("%s_data_L%0d", tag, l), rd[l], 32'h0);
    end
  endtask

  // Drive one command for one cycle and record its expected response.
  task automatic issue(input logic [1:0] c, input logic [31:0] a, input logic [31:0] d,
                       input logic ev, input logic ee, input logic [31:0] ed);
    exp_t x;
    cmd   = c;
    addr  = a;
    wdata = d;
    x = '{v: ev, e: ee, d: ed};
    for (int l = 0; l < NINST; l++) q[l].push_back(x);
    @(posedge clk);
    #1;
  endtask

  task automatic st(input logic [31:0] a, input logic [31:0] d, input logic ee);
    issue(2'h2, a, d, 1'b0, ee, 32'h0);
  endtask

  task automatic ld(input logic [31:0] a, input logic [31:0] ed, input logic ee);
    issue(2'h1, a, 32'h0, 1'b1, ee, ed);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) issue(2'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    cmd    = 2'h0;
    addr   = 32'h0;
    wdata  = 32'h0;
    rst    = 1'b1;
    #2 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_outputs_zero("reset");
    chk_all(16'h0, 16'h0, 1'b0);
    rst = 1'b1;

    // Store then immediately load the same word.
    st(32'h10, 32'hDEAD_BEEF, 1'b0);
    ld(32'h10, 32'hDEAD_BEEF, 1'b0);
    chk_all(16'd1, 16'd1, 1'b0);
    idle(4);

    // Preload words 0..3 and stream four back-to-back loads.
    st(32'h0, 32'h1, 1'b0);
    st(32'h4, 32'h2, 1'b0);
    st(32'h8, 32'h3, 1'b0);
    st(32'hC, 32'h4, 1'b0);
    ld(32'h0, 32'h1, 1'b0);
    ld(32'h4, 32'h2, 1'b0);
    ld(32'h8, 32'h3, 1'b0);
    ld(32'hC, 32'h4, 1'b0);
    idle(4);

    // Misaligned store must not touch the array but must set the sticky flag.
    st(32'h10, 32'h5A5A_5A5A, 1'b0);
    chk_all(16'd5, 16'd6, 1'b0);
    st(32'h13, 32'hFFFF_FFFF, 1'b1);
    chk_all(16'd5, 16'd7, 1'b1);
    ld(32'h10, 32'h5A5A_5A5A, 1'b0);
    idle(4);

    // Out-of-range load: index 1024 with DEPTH 1024.
    ld(32'h1000, 32'h0, 1'b1);
    chk_all(16'd7, 16'd7, 1'b1);
    idle(4);

    // Load captures old data; following store lands before the next load.
    st(32'h20, 32'h1, 1'b0);
    ld(32'h20, 32'h1, 1'b0);
    st(32'h20, 32'h2, 1'b0);
    ld(32'h20, 32'h2, 1'b0);
    // Undefined command code is a no-op even with a bad address.
    issue(2'h3, 32'h13, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0);
    ld(32'h10, 32'h5A5A_5A5A, 1'b0);
    chk_all(16'd10, 16'd9, 1'b1);
    idle(5);

    // Reset mid-cycle with loads in flight.
    ld(32'h0, 32'h1, 1'b0);
    ld(32'h4, 32'h2, 1'b0);
    cmd = 2'h0;
    #2 rst = 1'b0;
    for (int l = 0; l < NINST; l++) q[l].delete();
    #1;
    chk_outputs_zero("midrst");
    chk_all(16'h0, 16'h0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    idle(6);
    ld(32'h0, 32'h1, 1'b0);
    idle(4);
    chk_all(16'd1, 16'd0, 1'b0);

    // Store counter saturation.
    for (int i = 0; i < 65534; i++) st(32'h40, 32'(i), 1'b0);
    chk("st_count_pre_sat", 32'(sc[1]), 32'h0000_FFFE);
    st(32'h40, 32'h1234_0000, 1'b0);
    chk("st_count_at_sat", 32'(sc[1]), 32'h0000_FFFF);
    st(32'h40, 32'h1234_0001, 1'b0);
    st(32'h40, 32'h1234_0002, 1'b0);
    st(32'h40, 32'h1234_0003, 1'b0);
    chk_all(16'd1, 16'hFFFF, 1'b0);
    ld(32'h40, 32'h1234_0003, 1'b0);
    idle(5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
